// File: rtl/fpu_ss_csr_pkg.sv
// Shared types and constants for the FPU subsystem floating-point CSR block.
package fpu_ss_csr_pkg;

    typedef enum logic [1:0] {
        RW = 2'b00,
        RS = 2'b01,
        RC = 2'b10
    } csr_op_e;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic [2:0] frm;
        fflags_t    fflags;
    } fcsr_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RESP
    } fcsr_state_e;

    // Read-modify-write on an LSB-aligned field value; the reserved op leaves it untouched.
    function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                             input logic [7:0] old_val,
                                             input logic [7:0] src);
        logic [7:0] res;
        case (op)
            RW:      res = src;
            RS:      res = old_val | src;
            RC:      res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpu_ss_fcsr_ctrl_outstanding_cnt.sv
// In-flight FPU op counter: issue/retire accounting, saturation at zero and issue throttling.
module fpu_ss_outstanding_cnt #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   issue_i,
    input  logic                                   hold_i,
    input  logic [NUM_CH-1:0]                      retire_i,
    output logic                                   issue_ready_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   count_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int RET_W = $clog2(NUM_CH + 1);
    localparam int ACC_W = CNT_W + RET_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] retire_cnt, incoming;
    logic             underflow;

    assign issue_ready_o = !hold_i && (count_q != CNT_W'(MAX_OUTSTANDING));
    assign count_o       = count_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        retire_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            retire_cnt = retire_cnt + ACC_W'(retire_i[c]);
        end
        incoming  = ACC_W'(count_q) + ACC_W'(issue_i & issue_ready_o);
        underflow = retire_cnt > incoming;
        count_d   = underflow ? '0 : CNT_W'(incoming - retire_cnt);
    end

    // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            underflow_chk: assert (!underflow);
        end
    end

endmodule

// File: rtl/fpu_ss_fcsr_ctrl.sv
// fcsr holder: serves RW/RS/RC CSR requests once the FPU pipeline is drained and
// accumulates sticky exception flags from the retire channels.
module fpu_ss_fcsr_ctrl
    import fpu_ss_csr_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_req_valid_i,
    output logic                  csr_req_ready_o,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic                  csr_wr_suppress_i,
    input  logic                  csr_rd_nonzero_i,
    output logic                  csr_rsp_valid_o,
    input  logic                  csr_rsp_ready_i,
    output logic [31:0]           csr_rsp_rdata_o,
    output logic                  csr_rsp_wb_o,
    output logic                  csr_rsp_illegal_o,
    input  logic                  fpu_issue_i,
    output logic                  fpu_issue_ready_o,
    input  logic [NUM_CH-1:0]     fpu_retire_i,
    input  logic [NUM_CH*5-1:0]   fpu_status_i,
    output logic [2:0]            frm_o,
    output logic                  frm_invalid_o,
    output logic [4:0]            fflags_o,
    output logic                  busy_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    fcsr_state_e      state_q, state_d;
    fcsr_t            fcsr_q, fcsr_d;
    logic [1:0]       op_q;
    logic [11:0]      addr_q;
    logic [7:0]       wdata_q;
    logic             suppress_q, rd_nz_q;
    logic [7:0]       rdata_q;
    logic             wb_q, illegal_q;

    logic [CNT_W-1:0] count;
    logic             access, illegal, wr_en, req_accept;
    logic [7:0]       old_val, src_val, new_val;
    logic [4:0]       retire_flags;
    logic             unused_wdata;

    // Only the low byte of the operand can ever reach fcsr.
    assign unused_wdata = ^csr_wdata_i[31:8];

    fpu_ss_outstanding_cnt #(
        .NUM_CH         (NUM_CH),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_i      (fpu_issue_i),
        .hold_i       (state_q == DRAIN),
        .retire_i     (fpu_retire_i),
        .issue_ready_o(fpu_issue_ready_o),
        .count_o      (count)
    );

    assign req_accept = csr_req_valid_i && csr_req_ready_o;
    assign access     = (state_q == DRAIN) && (count == '0) && !(|fpu_retire_i);
    assign illegal    = !(addr_q inside {CSR_FFLAGS, CSR_FRM, CSR_FCSR}) || (op_q == 2'b11);
    assign wr_en      = access && !illegal && !suppress_q;
    assign new_val    = csr_apply(op_q, old_val, src_val);

    always_comb begin
        old_val = '0;
        src_val = '0;
        case (addr_q)
            CSR_FFLAGS: begin
                old_val = {3'b000, fcsr_q.fflags};
                src_val = {3'b000, wdata_q[4:0]};
            end
            CSR_FRM: begin
                old_val = {5'b00000, fcsr_q.frm};
                src_val = {5'b00000, wdata_q[2:0]};
            end
            CSR_FCSR: begin
                old_val = fcsr_q;
                src_val = wdata_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        retire_flags = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fpu_retire_i[c]) retire_flags = retire_flags | fpu_status_i[c*5 +: 5];
        end
        fcsr_d        = fcsr_q;
        fcsr_d.fflags = fcsr_q.fflags | retire_flags;
        // A CSR write overrides any flag accumulation on the same edge.
        if (wr_en) begin
            case (addr_q)
                CSR_FFLAGS: fcsr_d.fflags = new_val[4:0];
                CSR_FRM:    fcsr_d.frm    = new_val[2:0];
                default:    fcsr_d        = fcsr_t'(new_val);
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        csr_req_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                csr_req_ready_o = 1'b1;
                if (csr_req_valid_i) state_d = DRAIN;
            end
            DRAIN:   if (access) state_d = RESP;
            RESP:    if (csr_rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fcsr_q     <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            suppress_q <= 1'b0;
            rd_nz_q    <= 1'b0;
            rdata_q    <= '0;
            wb_q       <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcsr_q  <= fcsr_d;
            if (req_accept) begin
                op_q       <= csr_op_i;
                addr_q     <= csr_addr_i;
                wdata_q    <= csr_wdata_i[7:0];
                suppress_q <= csr_wr_suppress_i;
                rd_nz_q    <= csr_rd_nonzero_i;
            end
            if (access) begin
                rdata_q   <= illegal ? 8'h00 : old_val;
                wb_q      <= rd_nz_q && !illegal;
                illegal_q <= illegal;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            flag_write_chk: assert (!(wr_en && |fpu_retire_i));
        end
    end

    assign csr_rsp_valid_o   = (state_q == RESP);
    assign csr_rsp_rdata_o   = {24'h000000, rdata_q};
    assign csr_rsp_wb_o      = wb_q;
    assign csr_rsp_illegal_o = illegal_q;
    assign frm_o             = fcsr_q.frm;
    assign frm_invalid_o     = fcsr_q.frm inside {3'd5, 3'd6, 3'd7};
    assign fflags_o          = fcsr_q.fflags;
    assign busy_o            = (count != '0);

endmodule

// File: tb/tb_fpu_ss_fcsr_ctrl.sv
// Directed plus randomized bench for fpu_ss_fcsr_ctrl against a behavioural fcsr model.
module tb_fpu_ss_fcsr_ctrl;

    localparam int NUM_CH  = 2;
    localparam int MAX_OUT = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 csr_req_valid_i;
    logic                 csr_req_ready_o;
    logic [1:0]           csr_op_i;
    logic [11:0]          csr_addr_i;
    logic [31:0]          csr_wdata_i;
    logic                 csr_wr_suppress_i;
    logic                 csr_rd_nonzero_i;
    logic                 csr_rsp_valid_o;
    logic                 csr_rsp_ready_i;
    logic [31:0]          csr_rsp_rdata_o;
    logic                 csr_rsp_wb_o;
    logic                 csr_rsp_illegal_o;
    logic                 fpu_issue_i;
    logic                 fpu_issue_ready_o;
    logic [NUM_CH-1:0]    fpu_retire_i;
    logic [NUM_CH*5-1:0]  fpu_status_i;
    logic [2:0]           frm_o;
    logic                 frm_invalid_o;
    logic [4:0]           fflags_o;
    logic                 busy_o;

    fpu_ss_fcsr_ctrl #(
        .NUM_CH         (NUM_CH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .csr_req_valid_i  (csr_req_valid_i),
        .csr_req_ready_o  (csr_req_ready_o),
        .csr_op_i         (csr_op_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_wr_suppress_i(csr_wr_suppress_i),
        .csr_rd_nonzero_i (csr_rd_nonzero_i),
        .csr_rsp_valid_o  (csr_rsp_valid_o),
        .csr_rsp_ready_i  (csr_rsp_ready_i),
        .csr_rsp_rdata_o  (csr_rsp_rdata_o),
        .csr_rsp_wb_o     (csr_rsp_wb_o),
        .csr_rsp_illegal_o(csr_rsp_illegal_o),
        .fpu_issue_i      (fpu_issue_i),
        .fpu_issue_ready_o(fpu_issue_ready_o),
        .fpu_retire_i     (fpu_retire_i),
        .fpu_status_i     (fpu_status_i),
        .frm_o            (frm_o),
        .frm_invalid_o    (frm_invalid_o),
        .fflags_o         (fflags_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [2:0]  m_frm;
    logic [4:0]  m_fflags;
    int          m_cnt;
    bit          draining;
    logic [1:0]  p_op;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    bit          p_sup, p_rdnz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] rand_ret(input int lo, input int avail);
        int hi;
        int n;
        hi = (avail < 2) ? avail : 2;
        n  = (lo > hi) ? hi : int'($urandom_range(lo, hi));
        if (n == 0) return 2'b00;
        if (n == 2) return 2'b11;
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic fpu_cycle(input bit iss, input logic [1:0] ret, input logic [9:0] st);
        bit acc;
        acc = iss && !draining && (m_cnt < MAX_OUT);
        check("issue_ready", fpu_issue_ready_o, (!draining && m_cnt < MAX_OUT));
        fpu_issue_i  = iss;
        fpu_retire_i = ret;
        fpu_status_i = st;
        tick();
        fpu_issue_i  = 1'b0;
        fpu_retire_i = '0;
        fpu_status_i = '0;
        m_cnt = m_cnt + (acc ? 1 : 0) - $countones(ret);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ret[c]) m_fflags = m_fflags | st[c*5 +: 5];
        end
        check("fflags_acc", fflags_o, m_fflags);
        check("busy", busy_o, (m_cnt != 0));
        if (draining) begin
            check("drain_no_rsp", csr_rsp_valid_o, 0);
            check("drain_req_ready", csr_req_ready_o, 0);
        end
    endtask

    task automatic csr_send(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wdata, input bit sup, input bit rdnz);
        check("req_ready_idle", csr_req_ready_o, 1);
        csr_req_valid_i   = 1'b1;
        csr_op_i          = op;
        csr_addr_i        = addr;
        csr_wdata_i       = wdata;
        csr_wr_suppress_i = sup;
        csr_rd_nonzero_i  = rdnz;
        tick();
        csr_req_valid_i   = 1'b0;
        csr_wdata_i       = $urandom;
        p_op    = op;
        p_addr  = addr;
        p_wdata = wdata;
        p_sup   = sup;
        p_rdnz  = rdnz;
        draining = 1'b1;
    endtask

    task automatic csr_wait(input int exp_lat, input int hold);
        int         lat;
        bit         ill;
        logic [7:0] old, mask, src, nv;
        logic [31:0] exp_rd;
        lat = 0;
        while (csr_rsp_valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        ill  = !(p_addr inside {12'h001, 12'h002, 12'h003}) || (p_op == 2'b11);
        old  = 8'h00;
        mask = 8'h00;
        case (p_addr)
            12'h001: begin old = {3'b000, m_fflags};     mask = 8'h1F; end
            12'h002: begin old = {5'b00000, m_frm};      mask = 8'h07; end
            12'h003: begin old = {m_frm, m_fflags};      mask = 8'hFF; end
            default: ;
        endcase
        src = p_wdata[7:0] & mask;
        case (p_op)
            2'b00:   nv = src;
            2'b01:   nv = old | src;
            2'b10:   nv = old & ~src & mask;
            default: nv = old;
        endcase
        exp_rd = ill ? 32'h0 : {24'h0, old};
        if (!ill && !p_sup) begin
            case (p_addr)
                12'h001: m_fflags = nv[4:0];
                12'h002: m_frm    = nv[2:0];
                default: begin m_frm = nv[7:5]; m_fflags = nv[4:0]; end
            endcase
        end
        draining = 1'b0;
        check("rsp_rdata", csr_rsp_rdata_o, exp_rd);
        check("rsp_wb", csr_rsp_wb_o, (p_rdnz && !ill));
        check("rsp_illegal", csr_rsp_illegal_o, ill);
        for (int h = 0; h < hold; h++) begin
            csr_rsp_ready_i = 1'b0;
            tick();
            check("hold_valid", csr_rsp_valid_o, 1);
            check("hold_rdata", csr_rsp_rdata_o, exp_rd);
            check("hold_req_ready", csr_req_ready_o, 0);
        end
        csr_rsp_ready_i = 1'b1;
        tick();
        csr_rsp_ready_i = 1'b0;
        check("rsp_done", csr_rsp_valid_o, 0);
        check("req_ready_back", csr_req_ready_o, 1);
        check("frm", frm_o, m_frm);
        check("fflags", fflags_o, m_fflags);
        check("frm_invalid", frm_invalid_o, (m_frm >= 3'd5));
    endtask

    task automatic do_csr(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wdata, input bit sup, input bit rdnz, input int hold);
        csr_send(op, addr, wdata, sup, rdnz);
        csr_wait(1, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [2:0]  sv_frm;
        logic [4:0]  sv_fflags;
        logic [11:0] addr;
        int          sel, n, avail;
        bit          iss;

        rst_i = 1'b1;
        csr_req_valid_i = 1'b0;  csr_op_i = '0;  csr_addr_i = '0;  csr_wdata_i = '0;
        csr_wr_suppress_i = 1'b0;  csr_rd_nonzero_i = 1'b0;  csr_rsp_ready_i = 1'b0;
        fpu_issue_i = 1'b0;  fpu_retire_i = '0;  fpu_status_i = '0;
        m_frm = '0;  m_fflags = '0;  m_cnt = 0;  draining = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_req_ready", csr_req_ready_o, 1);
        check("rst_rsp_valid", csr_rsp_valid_o, 0);
        check("rst_rdata", csr_rsp_rdata_o, 0);
        check("rst_wb", csr_rsp_wb_o, 0);
        check("rst_illegal", csr_rsp_illegal_o, 0);
        check("rst_frm", frm_o, 0);
        check("rst_fflags", fflags_o, 0);
        check("rst_frm_invalid", frm_invalid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_issue_ready", fpu_issue_ready_o, 1);

        // RW fcsr with upper garbage bits
        do_csr(2'b00, 12'h003, 32'hFFFF_FFA5, 1'b0, 1'b1, 0);
        check("t1_frm", frm_o, 5);
        check("t1_fflags", fflags_o, 5'h05);
        check("t1_frm_invalid", frm_invalid_o, 1);

        // Two channels retire together, then a suppressed RS read
        do_csr(2'b00, 12'h001, 32'h0, 1'b0, 1'b0, 0);
        fpu_cycle(1'b1, 2'b00, 10'h0);
        fpu_cycle(1'b1, 2'b00, 10'h0);
        fpu_cycle(1'b0, 2'b11, {5'b01000, 5'b00001});
        check("t2_fflags", fflags_o, 5'h09);
        do_csr(2'b01, 12'h001, 32'h1F, 1'b1, 1'b1, 0);
        check("t2_fflags_kept", fflags_o, 5'h09);

        // CSR access waits for three in-flight ops to drain
        do_csr(2'b00, 12'h002, 32'h7, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) fpu_cycle(1'b1, 2'b00, 10'h0);
        csr_send(2'b10, 12'h002, 32'h3, 1'b0, 1'b1);
        check("t3_issue_blocked", fpu_issue_ready_o, 0);
        for (int i = 0; i < 3; i++) fpu_cycle(1'b1, 2'b01, 10'h0);
        csr_wait(1, 0);
        check("t3_frm", frm_o, 4);

        // Counter full, issue+retire on the same cycle
        for (int i = 0; i < 4; i++) fpu_cycle(1'b1, 2'b00, 10'h0);
        check("t4_full", fpu_issue_ready_o, 0);
        fpu_cycle(1'b1, 2'b01, 10'h0);
        fpu_cycle(1'b1, 2'b01, 10'h0);
        fpu_cycle(1'b1, 2'b00, 10'h0);
        check("t4_full_again", fpu_issue_ready_o, 0);
        fpu_cycle(1'b0, 2'b11, 10'h0);
        fpu_cycle(1'b0, 2'b11, 10'h0);

        // Illegal address and reserved op
        sv_frm = frm_o;
        sv_fflags = fflags_o;
        do_csr(2'b00, 12'h004, 32'hFF, 1'b0, 1'b1, 0);
        do_csr(2'b11, 12'h003, 32'hFF, 1'b0, 1'b1, 0);
        check("t5_frm_kept", frm_o, 4);
        check("t5_fflags_kept", fflags_o, 5'h09);

        // Backpressured response, then reset while draining
        do_csr(2'b01, 12'h001, 32'h3, 1'b0, 1'b1, 5);
        fpu_cycle(1'b1, 2'b00, 10'h0);
        csr_send(2'b00, 12'h003, 32'hFF, 1'b0, 1'b1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m_frm = '0;  m_fflags = '0;  m_cnt = 0;  draining = 1'b0;
        check("t6_req_ready", csr_req_ready_o, 1);
        check("t6_rsp_valid", csr_rsp_valid_o, 0);
        check("t6_frm", frm_o, 0);
        check("t6_fflags", fflags_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_issue_ready", fpu_issue_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_rsp", csr_rsp_valid_o, 0);
        end

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                iss   = 1'($urandom_range(0, 1));
                avail = m_cnt + ((iss && m_cnt < MAX_OUT) ? 1 : 0);
                fpu_cycle(iss, rand_ret(0, avail), 10'($urandom));
            end
            sel = $urandom_range(0, 7);
            addr = (sel <= 5) ? 12'(sel % 3 + 1) : 12'($urandom);
            csr_send(2'($urandom_range(0, 3)), addr, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            while (m_cnt > 0) begin
                fpu_cycle(1'($urandom_range(0, 1)), rand_ret(1, m_cnt), 10'($urandom));
            end
            csr_wait(1, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
